// File: rtl/tg_sequencer_if.sv
// Handshake/config bundle between the traffic-generator sequencer and its host.
// master: host side (table writes, control, stream snoop); slave: sequencer side.
interface tg_sequencer_if #(
  parameter int AW = 3
);
  logic           cfg_wr_en;
  logic [AW-1:0]  cfg_wr_addr;
  logic [223:0]   cfg_wr_data;
  logic           start;
  logic           stop;
  logic [AW:0]    num_entries;
  logic           loop_table;
  logic [31:0]    tg_mode;
  logic [31:0]    tg_num_packets;
  logic [31:0]    tg_num_flits;
  logic [31:0]    tg_last_flit_bytes;
  logic [31:0]    tg_M;
  logic [31:0]    tg_N;
  logic           tg_tvalid;
  logic           tg_tready;
  logic           tg_tlast;
  logic           busy;
  logic           done;
  logic [AW-1:0]  cur_entry;
  logic [15:0]    pkt_count;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data,
    output start, stop, num_entries, loop_table,
    output tg_tvalid, tg_tready, tg_tlast,
    input  tg_mode, tg_num_packets, tg_num_flits,
    input  tg_last_flit_bytes, tg_M, tg_N,
    input  busy, done, cur_entry, pkt_count
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data,
    input  start, stop, num_entries, loop_table,
    input  tg_tvalid, tg_tready, tg_tlast,
    output tg_mode, tg_num_packets, tg_num_flits,
    output tg_last_flit_bytes, tg_M, tg_N,
    output busy, done, cur_entry, pkt_count
  );
endinterface

// File: rtl/tg_sequencer.sv
// Runtime sequencer for the AXIS traffic generator: walks a config table,
// enables the generator per entry, counts packets, inserts idle gaps.
// Ports: clk, rst (sync, active-high), bus (tg_sequencer_if.slave).
module tg_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  tg_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_RUN, S_GAP
  } state_t;

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_ONE   = {{AW{1'b0}}, 1'b1};

  state_t         r_state;
  state_t         w_state_nxt;
  logic [223:0]   r_tbl [DEPTH];
  logic [AW-1:0]  r_cur;
  logic [AW-1:0]  w_cur_nxt;
  logic [31:0]    r_mode;
  logic [31:0]    r_npk;
  logic [31:0]    r_nfl;
  logic [31:0]    r_lfb;
  logic [31:0]    r_m;
  logic [31:0]    r_n;
  logic [15:0]    r_gap;
  logic [15:0]    r_gcnt;
  logic [15:0]    r_pcnt;
  logic           r_stop_pend;
  logic           r_done;
  logic           w_done_nxt;
  logic           w_hs;
  logic           w_skip;
  logic           w_stop;
  logic           w_more;
  logic           w_gap_end;
  logic           w_busy;
  logic           w_en;
  logic [AW:0]    w_ne;
  logic [15:0]    w_pcnt_inc;
  logic [15:0]    w_gap_eff;

  assign w_ne = (bus.num_entries > L_DEPTH) ? L_DEPTH
                                            : bus.num_entries;
  assign w_more = (({1'b0, r_cur}) + L_ONE) < w_ne;
  assign w_hs = bus.tg_tvalid & bus.tg_tready
              & bus.tg_tlast;
  // r_* already hold the entry being loaded while in LOAD
  assign w_skip = (r_npk[15:0] == 16'd0) | ~r_mode[0];
  assign w_stop = bus.stop | r_stop_pend;
  assign w_pcnt_inc = (r_pcnt == 16'hFFFF) ? r_pcnt
                                           : r_pcnt + 16'd1;
  assign w_gap_eff = (r_gap == 16'd0) ? 16'd1 : r_gap;
  assign w_gap_end = (r_gcnt == w_gap_eff - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (w_ne != '0) begin
            w_state_nxt = S_LOAD;
            w_cur_nxt   = '0;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_skip) begin
          w_state_nxt = S_GAP;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // a pending stop waits for a packet boundary
        if (w_hs && w_stop) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_hs && w_pcnt_inc == r_npk[15:0]) begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_gap_end) begin
          if (w_more) begin
            w_state_nxt = S_LOAD;
            w_cur_nxt   = r_cur + 1'b1;
          end else if (bus.loop_table) begin
            w_state_nxt = S_LOAD;
            w_cur_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_en   = (r_state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_tbl[i] <= '0;
      r_cur       <= '0;
      r_mode      <= '0;
      r_npk       <= '0;
      r_nfl       <= '0;
      r_lfb       <= '0;
      r_m         <= '0;
      r_n         <= '0;
      r_gap       <= '0;
      r_gcnt      <= '0;
      r_pcnt      <= '0;
      r_stop_pend <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (bus.cfg_wr_en)
        r_tbl[bus.cfg_wr_addr] <= bus.cfg_wr_data;
      r_cur  <= w_cur_nxt;
      r_done <= w_done_nxt;
      // config is presented during LOAD so the generator
      // sees it for a full cycle with en low
      if (w_state_nxt == S_LOAD) begin
        r_mode <= {r_tbl[w_cur_nxt][31:4], 1'b0,
                   r_tbl[w_cur_nxt][2:0]};
        r_npk  <= r_tbl[w_cur_nxt][63:32];
        r_nfl  <= r_tbl[w_cur_nxt][95:64];
        r_lfb  <= r_tbl[w_cur_nxt][127:96];
        r_m    <= r_tbl[w_cur_nxt][159:128];
        r_n    <= r_tbl[w_cur_nxt][191:160];
        r_gap  <= r_tbl[w_cur_nxt][207:192];
        r_pcnt <= '0;
        r_gcnt <= '0;
      end else begin
        if (r_state == S_RUN && w_hs)
          r_pcnt <= w_pcnt_inc;
        if (r_state == S_GAP)
          r_gcnt <= r_gcnt + 16'd1;
      end
      if (r_state == S_RUN && w_state_nxt == S_RUN)
        r_stop_pend <= r_stop_pend | bus.stop;
      else
        r_stop_pend <= 1'b0;
    end
  end

  assign bus.tg_mode            = {r_mode[31:1], w_en};
  assign bus.tg_num_packets     = r_npk;
  assign bus.tg_num_flits       = r_nfl;
  assign bus.tg_last_flit_bytes = r_lfb;
  assign bus.tg_M               = r_m;
  assign bus.tg_N               = r_n;
  assign bus.busy               = w_busy;
  assign bus.done               = r_done;
  assign bus.cur_entry          = r_cur;
  assign bus.pkt_count          = r_pcnt;

endmodule
